// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller handshake bundle.
// Pipeline status in, stage enables and counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic             id_rs1_used_i;
  logic             id_rs2_used_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rd_i;
  logic             branch_taken_i;
  logic             exmem_memreq_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             back_write_o;
  logic             stall_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic             err_o;

  modport master (
    output start_i, id_rs1_i, id_rs2_i,
    output id_rs1_used_i, id_rs2_used_i,
    output idex_memread_i, idex_rd_i,
    output branch_taken_i,
    output exmem_memreq_i, mem_ready_i,
    input  pc_write_o, ifid_write_o,
    input  ifid_flush_o, idex_bubble_o,
    input  back_write_o, stall_o,
    input  stall_cnt_o, flush_cnt_o, err_o
  );

  modport slave (
    input  start_i, id_rs1_i, id_rs2_i,
    input  id_rs1_used_i, id_rs2_used_i,
    input  idex_memread_i, idex_rd_i,
    input  branch_taken_i,
    input  exmem_memreq_i, mem_ready_i,
    output pc_write_o, ifid_write_o,
    output ifid_flush_o, idex_bubble_o,
    output back_write_o, stall_o,
    output stall_cnt_o, flush_cnt_o, err_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Load-use stall, branch flush, data-memory freeze.
module pipeline_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    MEM_WAIT
  } state_t;

  state_t           state, state_n;
  logic [WW-1:0]    wcnt, wcnt_n;
  logic             err, err_n;
  logic [CNT_W-1:0] scnt, fcnt;
  logic             s_inc, f_inc;
  logic             pc_w, ifid_w, ifid_f;
  logic             bubble, back_w, stall;
  logic             freeze, hit1, hit2, lu;

  assign freeze = bus.exmem_memreq_i
                & ~bus.mem_ready_i;
  assign hit1 = bus.id_rs1_used_i
              & (bus.id_rs1_i == bus.idex_rd_i);
  assign hit2 = bus.id_rs2_used_i
              & (bus.id_rs2_i == bus.idex_rd_i);
  // x0 is hard-wired zero, so a load into it never hazards
  assign lu = bus.idex_memread_i
            & (bus.idex_rd_i != 5'd0)
            & (hit1 | hit2);

  // State, wait counter and sticky error register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      wcnt  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      err   <= err_n;
    end
  end

  // Saturating stall/flush counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scnt <= '0;
      fcnt <= '0;
    end else begin
      if (s_inc && scnt != '1)
        scnt <= scnt + 1'b1;
      if (f_inc && fcnt != '1)
        fcnt <= fcnt + 1'b1;
    end
  end

  // Next state and stage enables
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    err_n   = err;
    s_inc   = 1'b0;
    f_inc   = 1'b0;
    pc_w    = 1'b0;
    ifid_w  = 1'b0;
    ifid_f  = 1'b0;
    bubble  = 1'b1;
    back_w  = 1'b1;
    stall   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start_i)
          state_n = RUN;
      end
      RUN: begin
        if (freeze) begin
          back_w  = 1'b0;
          bubble  = 1'b0;
          state_n = MEM_WAIT;
          wcnt_n  = WW'(1);
        end else begin
          if (lu) begin
            stall = 1'b1;
            s_inc = 1'b1;
          end else if (bus.branch_taken_i) begin
            pc_w   = 1'b1;
            ifid_w = 1'b1;
            ifid_f = 1'b1;
            bubble = 1'b0;
            f_inc  = 1'b1;
          end else begin
            pc_w   = 1'b1;
            ifid_w = 1'b1;
            bubble = 1'b0;
          end
          if (!bus.start_i)
            state_n = IDLE;
        end
      end
      MEM_WAIT: begin
        back_w = 1'b0;
        bubble = 1'b0;
        if (bus.mem_ready_i) begin
          state_n = RUN;
          wcnt_n  = '0;
        end else if (32'(wcnt) >= TIMEOUT - 1) begin
          err_n   = 1'b1;
          state_n = IDLE;
          wcnt_n  = '0;
        end else begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.pc_write_o    = pc_w;
  assign bus.ifid_write_o  = ifid_w;
  assign bus.ifid_flush_o  = ifid_f;
  assign bus.idex_bubble_o = bubble;
  assign bus.back_write_o  = back_w;
  assign bus.stall_o       = stall;
  assign bus.stall_cnt_o   = scnt;
  assign bus.flush_cnt_o   = fcnt;
  assign bus.err_o         = err;

endmodule
